// File: rtl/forward_hazard_unit_pkg.sv
// Shared definitions for the EX-stage forwarding / load-use hazard unit.
// Forward-mux select codes and the hard-wired zero register index.
package forward_hazard_unit_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/forward_hazard_unit_fwd_select.sv
// Combinational forward-select for one source operand.
// The newer producer (currently in EX, landing in MEM) wins over the older one in MEM.
module fwd_select
    import forward_hazard_unit_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             ex_regwrite,
    input  logic [REG_W-1:0] mem_dst,
    input  logic             mem_regwrite,
    output logic [1:0]       code
);

    localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(REG_ZERO);

    always_comb begin
        code = FWD_RF;
        if (ex_regwrite && (ex_dst != ZERO_IDX) && (ex_dst == src)) begin
            code = FWD_MEM;
        end else if (mem_regwrite && (mem_dst != ZERO_IDX) && (mem_dst == src)) begin
            code = FWD_WB;
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// Tracks in-flight destination info and produces registered EX forward selects,
// a combinational load-use stall request and a saturating stall counter.
module forward_hazard_unit
    import forward_hazard_unit_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(REG_ZERO);

    logic [REG_W-1:0] ex_dst;
    logic             ex_regwrite;
    logic             ex_memread;
    logic [REG_W-1:0] mem_dst;
    logic             mem_regwrite;
    logic             bubble;
    logic [1:0]       sel_a;
    logic [1:0]       sel_b;

    assign stall = id_valid && !flush && ex_memread && (ex_dst != ZERO_IDX) &&
                   ((ex_dst == id_rs) || (ex_dst == id_rt));

    assign bubble = flush || stall || !id_valid;

    fwd_select #(.REG_W(REG_W)) u_sel_a (
        .src          (id_rs),
        .ex_dst       (ex_dst),
        .ex_regwrite  (ex_regwrite),
        .mem_dst      (mem_dst),
        .mem_regwrite (mem_regwrite),
        .code         (sel_a)
    );

    fwd_select #(.REG_W(REG_W)) u_sel_b (
        .src          (id_rt),
        .ex_dst       (ex_dst),
        .ex_regwrite  (ex_regwrite),
        .mem_dst      (mem_dst),
        .mem_regwrite (mem_regwrite),
        .code         (sel_b)
    );

    // WB slot needs no storage: WB-vs-ID overlap is resolved by the write-first register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_dst       <= '0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            mem_dst      <= '0;
            mem_regwrite <= 1'b0;
            fwd_a        <= FWD_RF;
            fwd_b        <= FWD_RF;
            stall_cnt    <= '0;
        end else begin
            mem_dst      <= ex_dst;
            mem_regwrite <= ex_regwrite;
            if (bubble) begin
                ex_dst      <= '0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                fwd_a       <= FWD_RF;
                fwd_b       <= FWD_RF;
            end else begin
                ex_dst      <= id_dst;
                ex_regwrite <= id_regwrite;
                ex_memread  <= id_memread;
                fwd_a       <= sel_a;
                fwd_b       <= sel_b;
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Self-checking bench: timeline model of issued instructions plus directed scenarios.
module tb_forward_hazard_unit;

    localparam int REG_W = 5;
    localparam int CNT_W = 3;
    localparam int DEPTH = 1024;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid = 1'b0;
    logic [REG_W-1:0] id_rs = '0;
    logic [REG_W-1:0] id_rt = '0;
    logic [REG_W-1:0] id_dst = '0;
    logic             id_regwrite = 1'b0;
    logic             id_memread = 1'b0;
    logic             flush = 1'b0;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    forward_hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_dst      (id_dst),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall       (stall),
        .stall_cnt   (stall_cnt)
    );

    int errors = 0;
    int checks = 0;
    logic started = 1'b0;

    // Timeline: what entered EX on each clock edge (index n = most recent edge).
    logic             iss_v  [DEPTH];
    logic [REG_W-1:0] iss_dst[DEPTH];
    logic [REG_W-1:0] iss_rs [DEPTH];
    logic [REG_W-1:0] iss_rt [DEPTH];
    logic             iss_rw [DEPTH];
    logic             iss_mr [DEPTH];
    int n = 2;
    int m_cnt = 0;
    logic m_st;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic m_stall();
        return id_valid && !flush && iss_v[n] && iss_mr[n] && (iss_dst[n] != 0) &&
               ((iss_dst[n] == id_rs) || (iss_dst[n] == id_rt));
    endfunction

    function automatic logic produces(input int k, input logic [REG_W-1:0] src);
        return iss_v[k] && iss_rw[k] && (iss_dst[k] != 0) && (iss_dst[k] == src);
    endfunction

    // Producer issued one edge earlier sits in MEM, two edges earlier sits in WB.
    function automatic logic [1:0] e_fwd(input bit use_rt);
        logic [REG_W-1:0] src;
        src = use_rt ? iss_rt[n] : iss_rs[n];
        if (!iss_v[n]) return 2'b00;
        if (produces(n - 1, src)) return 2'b10;
        if (produces(n - 2, src)) return 2'b01;
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 2;
            m_cnt = 0;
            for (int i = 0; i < 3; i++) begin
                iss_v[i] = 1'b0; iss_dst[i] = '0; iss_rs[i] = '0;
                iss_rt[i] = '0; iss_rw[i] = 1'b0; iss_mr[i] = 1'b0;
            end
        end else begin
            m_st = m_stall();
            if (m_st && m_cnt < CNT_MAX) m_cnt++;
            if (n < DEPTH - 1) n++;
            iss_v[n]   = id_valid && !flush && !m_st;
            iss_dst[n] = id_dst;
            iss_rs[n]  = id_rs;
            iss_rt[n]  = id_rt;
            iss_rw[n]  = id_regwrite;
            iss_mr[n]  = id_memread;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_stall", {31'b0, stall}, {31'b0, m_stall()});
            chk("model_fwd_a", {30'b0, fwd_a}, {30'b0, e_fwd(1'b0)});
            chk("model_fwd_b", {30'b0, fwd_b}, {30'b0, e_fwd(1'b1)});
            chk("model_stall_cnt", {29'b0, stall_cnt}, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt);
        id_valid = 1'b1; id_rs = rs; id_rt = rt; id_dst = rd;
        id_regwrite = 1'b1; id_memread = 1'b0;
    endtask

    task automatic lw(input logic [REG_W-1:0] rt, input logic [REG_W-1:0] base);
        id_valid = 1'b1; id_rs = base; id_rt = rt; id_dst = rt;
        id_regwrite = 1'b1; id_memread = 1'b1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_dst = '0;
        id_regwrite = 1'b0; id_memread = 1'b0;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        started = 1'b1;
        chk("reset_fwd_a", {30'b0, fwd_a}, 32'd0);
        chk("reset_stall_cnt", {29'b0, stall_cnt}, 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;

        // add $3 ; sub $4,$3,$5
        alu(3, 1, 2); tick();
        alu(4, 3, 5); tick();
        chk("t2_fwd_a", {30'b0, fwd_a}, 32'd2);
        chk("t2_fwd_b", {30'b0, fwd_b}, 32'd0);

        // add $3 ; nop ; or $6,$5,$3
        alu(3, 1, 2); tick();
        alu(0, 0, 0); tick();
        alu(6, 5, 3); tick();
        chk("t3_fwd_a", {30'b0, fwd_a}, 32'd0);
        chk("t3_fwd_b", {30'b0, fwd_b}, 32'd1);

        // add $3 ; add $3 ; and $7,$3,$3
        alu(3, 1, 2); tick();
        alu(3, 4, 5); tick();
        alu(7, 3, 3); tick();
        chk("t4_fwd_a", {30'b0, fwd_a}, 32'd2);
        chk("t4_fwd_b", {30'b0, fwd_b}, 32'd2);

        // lw $2 ; add $4,$2,$2
        lw(2, 1); tick();
        alu(4, 2, 2); #1;
        chk("t5_stall_on", {31'b0, stall}, 32'd1);
        chk("t5_cnt_before", {29'b0, stall_cnt}, 32'd0);
        tick();
        chk("t5_stall_off", {31'b0, stall}, 32'd0);
        chk("t5_cnt_after", {29'b0, stall_cnt}, 32'd1);
        chk("t5_bubble_fwd_a", {30'b0, fwd_a}, 32'd0);
        tick();
        chk("t5_fwd_a", {30'b0, fwd_a}, 32'd1);
        chk("t5_fwd_b", {30'b0, fwd_b}, 32'd1);

        // $0 is never forwarded nor a load-use hazard
        alu(0, 1, 2); tick();
        alu(5, 0, 0); tick();
        chk("zero_fwd_a", {30'b0, fwd_a}, 32'd0);
        chk("zero_fwd_b", {30'b0, fwd_b}, 32'd0);
        lw(0, 1); tick();
        alu(5, 0, 0); #1;
        chk("zero_lw_stall", {31'b0, stall}, 32'd0);
        tick();

        // lw $2 in EX, dependent in ID with flush
        lw(2, 1); tick();
        alu(4, 2, 3); flush = 1'b1; #1;
        chk("t6_stall", {31'b0, stall}, 32'd0);
        tick();
        flush = 1'b0; idle();
        chk("t6_fwd_a", {30'b0, fwd_a}, 32'd0);
        chk("t6_cnt", {29'b0, stall_cnt}, 32'd1);
        tick();

        // asynchronous reset mid-run with slots loaded and a stall pending
        alu(3, 1, 2); tick();
        lw(2, 3); tick();
        chk("t1_pre_fwd_a", {30'b0, fwd_a}, 32'd2);
        alu(8, 2, 2); #1;
        chk("t1_pre_stall", {31'b0, stall}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t1_fwd_a", {30'b0, fwd_a}, 32'd0);
        chk("t1_fwd_b", {30'b0, fwd_b}, 32'd0);
        chk("t1_stall", {31'b0, stall}, 32'd0);
        chk("t1_cnt", {29'b0, stall_cnt}, 32'd0);
        idle();
        @(negedge clk); #1 rst_n = 1'b1;
        tick();

        // counter saturation: nine load-use stalls
        for (int i = 0; i < 9; i++) begin
            lw(2, 1); tick();
            alu(4, 2, 2); tick();
            tick();
        end
        idle(); tick();
        chk("sat_cnt", {29'b0, stall_cnt}, CNT_MAX);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
